// File: rtl/mult_result_accum_pkg.sv
// Shared definitions for the multiplier result accumulator.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mult_result_accum_pkg;

  // Default product width of the upstream 4x4 sequential multiplier.
  localparam int PROD_W_DEF = 8;

  // ACCUM collects products; HOLD presents a finished group sum until it is accepted.
  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

endpackage

// File: rtl/mult_result_accum_rise_edge_det.sv
// Rising-edge detector: one-cycle pulse on each low-to-high transition of d.
// Latency: pulse is combinational from d and the registered previous value.
// Backpressure: none; the previous-value register updates every cycle.
module mult_result_accum_rise_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic pulse
);

  logic d_q;

  // Remember last cycle's level so a held-high input only pulses once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) d_q <= 1'b0;
    else     d_q <= d;
  end

  assign pulse = d & ~d_q;

endmodule

// File: rtl/mult_result_accum.sv
// Sums N_TERMS multiplier products (one per done edge) and offers the group sum on valid/ready.
// Latency: sum_valid rises the cycle after the edge that samples the last product of a group.
// Backpressure: while sum_valid&~sum_ready, new products are dropped and overrun is set (sticky).
// Option: define MULT_ACCUM_SAT_EN to make every add saturate at 2^ACC_W-1 instead of wrapping.
module mult_result_accum
  import mult_result_accum_pkg::*;
#(
  parameter int PROD_W  = PROD_W_DEF,
  parameter int N_TERMS = 4,
  parameter int ACC_W   = 10,
  localparam int CNT_W  = $clog2(N_TERMS) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              done_in,
  input  logic [PROD_W-1:0] product_in,
  output logic [ACC_W-1:0]  sum_out,
  output logic              sum_valid,
  input  logic              sum_ready,
  output logic [CNT_W-1:0]  term_cnt,
  output logic              overrun
);

  localparam logic [CNT_W-1:0] LAST_TERM = CNT_W'(N_TERMS - 1);

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] sum_d;
  logic             vld_d;
  logic [CNT_W-1:0] cnt_d;
  logic             ovr_d;
  logic             cap;
  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W-1:0] add_res;

  mult_result_accum_rise_edge_det u_rise_edge_det (
    .clk   (clk),
    .rst   (rst),
    .d     (done_in),
    .pulse (cap)
  );

  assign prod_ext = ACC_W'(product_in);

`ifdef MULT_ACCUM_SAT_EN
  logic [ACC_W:0] add_full;
  assign add_full = {1'b0, acc_q} + {1'b0, prod_ext};
  assign add_res  = add_full[ACC_W] ? {ACC_W{1'b1}} : add_full[ACC_W-1:0];
`else
  assign add_res = acc_q + prod_ext;
`endif

  // Next-state and datapath decisions; clr overrides everything, including a coincident capture.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    sum_d   = sum_out;
    vld_d   = sum_valid;
    cnt_d   = term_cnt;
    ovr_d   = overrun;
    if (clr) begin
      state_d = ST_ACCUM;
      acc_d   = '0;
      vld_d   = 1'b0;
      cnt_d   = '0;
      ovr_d   = 1'b0;
    end else begin
      case (state_q)
        ST_ACCUM: begin
          if (cap) begin
            if (term_cnt == LAST_TERM) begin
              sum_d   = add_res;
              vld_d   = 1'b1;
              acc_d   = '0;
              cnt_d   = '0;
              state_d = ST_HOLD;
            end else begin
              acc_d = add_res;
              cnt_d = term_cnt + CNT_W'(1);
            end
          end
        end
        ST_HOLD: begin
          if (sum_ready) begin
            vld_d   = 1'b0;
            state_d = ST_ACCUM;
            // A product arriving with the accept starts the next group rather than being lost.
            if (cap) begin
              acc_d = prod_ext;
              cnt_d = CNT_W'(1);
            end
          end else if (cap) begin
            ovr_d = 1'b1;
          end
        end
        default: state_d = ST_ACCUM;
      endcase
    end
  end

  // Group state registers; sum_out is only loaded on group completion so it is stable while valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_ACCUM;
      acc_q     <= '0;
      sum_out   <= '0;
      sum_valid <= 1'b0;
      term_cnt  <= '0;
      overrun   <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      sum_out   <= sum_d;
      sum_valid <= vld_d;
      term_cnt  <= cnt_d;
      overrun   <= ovr_d;
    end
  end

endmodule
